mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter that shares the single 128-bit main-memory line port between the instruction cache and the data cache. Each cache drives a line-refill/write-back request (req, write enable, line address, 128-bit write data) and waits for a ready pulse. The arbiter grants one requester at a time using round-robin and registers the winner's request onto the memory port. It routes the memory's ready pulse back only to the granted cache.

## Interface
- ADDR_WIDTH, 32, byte address width of line requests
- LINE_WIDTH, 128, cache line width in bits
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- i_req  in  1  icache request, held until i_ready
- i_we  in  1  icache write (1) / read (0)
- i_addr  in  ADDR_WIDTH  icache line address, [3:0] = 0
- i_wdata  in  LINE_WIDTH  icache write-back line
- i_rdata  out  LINE_WIDTH  refill line to icache
- i_ready  out  1  one-cycle completion pulse to icache
- d_req, d_we, d_addr, d_wdata, d_rdata, d_ready: same as the i_* ports, for the dcache
- m_req  out  1  request to main memory
- m_we  out  1  write enable to main memory
- m_addr  out  ADDR_WIDTH  line address to main memory
- m_wdata  out  LINE_WIDTH  write line to main memory
- m_rdata  in  LINE_WIDTH  read line from main memory
- m_ready  in  1  one-cycle completion pulse from main memory

## Operation
- FSM states: ARB_IDLE, ARB_GNT_I, ARB_GNT_D.
- ARB_IDLE:
  - Only i_req -> ARB_GNT_I. Only d_req -> ARB_GNT_D. Neither -> stay.
  - Both -> grant the port that is not last_grant.
- On entering a grant state, register req/we/addr/wdata of the winner into m_*, set m_req = 1, and update last_grant.
- The latched request is held constant for the whole grant, even if the requester's inputs change.
- ARB_GNT_x:
  - Hold m_* until m_ready.
  - On m_ready: pulse x_ready combinationally in the same cycle, clear m_req at the edge, and return to ARB_IDLE.
- m_ready in ARB_IDLE is ignored and not forwarded. At most one of i_ready/d_ready is high in any cycle.
- i_rdata and d_rdata are both driven from m_rdata continuously. A cache may only capture it when its own ready is high.
- Back-to-back transactions from one cache (dirty write-back followed by refill, req held high throughout) are two separate grants. The second grant is re-arbitrated, so the other cache may be served in between.
- A requester dropping req mid-grant is illegal; the transaction still completes and the ready pulse is still issued.

## Timing
- Reset values: m_req = 0, m_we = 0, m_addr = 0, m_wdata = 0, i_ready = 0, d_ready = 0, state = ARB_IDLE, last_grant = I (so the first simultaneous request goes to D).
- Grant latency: req sampled high in cycle 0 -> m_req high in cycle 1.
- Completion: x_ready is in the same cycle as m_ready; the arbiter is in ARB_IDLE the next cycle.
- Minimum spacing between grants: one ARB_IDLE bubble cycle. m_req is low for at least one cycle between transactions.
- Reset mid-transaction aborts immediately: all outputs return to reset values and any in-flight m_ready is ignored.
- Round-robin is strictly alternating under continuous contention, so no starvation. Worst-case wait is one full foreign transaction plus one bubble.

## Structure
- Package mem_arb_pkg:
  - arb_state_t enum (ARB_IDLE, ARB_GNT_I, ARB_GNT_D).
  - Port-id localparams PORT_I = 1'b0, PORT_D = 1'b1.
  - Default widths.
- Sub-module rr_pick2: combinational 2-way round-robin selector. Inputs are req[1:0] and last; outputs are gnt_valid and gnt_id. Instantiated once.
- Top module contains the FSM, last_grant register, output registers, and ready/rdata routing.

## Test plan
- Single icache read: i_req = 1, i_addr = 0x0000_1230, memory ready 3 cycles later with m_rdata = 0xA5..A5 -> m_addr = 0x0000_1230 and m_we = 0 from cycle 1; i_ready pulses once with i_rdata = 0xA5..A5; d_ready stays 0.
- Simultaneous first requests: i_req = d_req = 1 in cycle 0 after reset -> D granted first (m_addr = d_addr). After d_ready, one bubble cycle, then I granted.
- Dcache write-back then refill with d_req held high while i_req is also high -> order D(we = 1, addr 0x0000_0800, wdata latched), I, D(we = 0). Each grant has exactly one ready pulse.
- Input change mid-grant: d_addr changes from 0x40 to 0x80 during an active D grant -> m_addr stays 0x40 until m_ready.
- Stray m_ready in ARB_IDLE -> no i_ready/d_ready pulse and no state change.
- rst asserted during ARB_GNT_I with m_req = 1 -> m_req = 0 immediately (asynchronous). After release, a pending d_req is granted normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the I/D cache to main-memory arbiter.
// Port ids double as the round-robin history bit.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int LINE_W_DEF = 128;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GNT_I = 2'd1,
    ARB_GNT_D = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: on contention the port that did not
// win last time is chosen.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_id
);

  always_comb begin
    gnt_valid = |req;
    gnt_id    = PORT_I;
    case (req)
      2'b11:   gnt_id = ~last;
      2'b10:   gnt_id = PORT_D;
      default: gnt_id = PORT_I;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single main-memory line port between icache and dcache,
// one registered transaction at a time with round-robin arbitration.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W_DEF,
  parameter int LINE_WIDTH = LINE_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [LINE_WIDTH-1:0] i_wdata,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_ready,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_ready,
  output logic                  m_req,
  output logic                  m_we,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [LINE_WIDTH-1:0] m_wdata,
  input  logic [LINE_WIDTH-1:0] m_rdata,
  input  logic                  m_ready
);

  arb_state_t state;
  logic       last_grant;
  logic       gnt_valid;
  logic       gnt_id;

  rr_pick2 u_pick (
    .req       ({d_req, i_req}),
    .last      (last_grant),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ARB_IDLE;
      last_grant <= PORT_I;
      m_req      <= 1'b0;
      m_we       <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (gnt_valid) begin
            state      <= (gnt_id == PORT_D) ? ARB_GNT_D : ARB_GNT_I;
            last_grant <= gnt_id;
            m_req      <= 1'b1;
            m_we       <= (gnt_id == PORT_D) ? d_we : i_we;
            m_addr     <= (gnt_id == PORT_D) ? d_addr : i_addr;
            m_wdata    <= (gnt_id == PORT_D) ? d_wdata : i_wdata;
          end
        end
        ARB_GNT_I, ARB_GNT_D: begin
          if (m_ready) begin
            state <= ARB_IDLE;
            m_req <= 1'b0;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // Ready is steered combinationally so completion lands in the m_ready cycle.
  assign i_ready = (state == ARB_GNT_I) && m_ready;
  assign d_ready = (state == ARB_GNT_D) && m_ready;
  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-level model
// of the round-robin line-port sharing rules.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_req, i_we, i_ready;
  logic [31:0]  i_addr;
  logic [127:0] i_wdata, i_rdata;
  logic         d_req, d_we, d_ready;
  logic [31:0]  d_addr;
  logic [127:0] d_wdata, d_rdata;
  logic         m_req, m_we, m_ready;
  logic [31:0]  m_addr;
  logic [127:0] m_wdata, m_rdata;

  int checks = 0;
  int errors = 0;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_we(i_we), .i_addr(i_addr),
    .i_wdata(i_wdata), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ready(d_ready),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Model: one outstanding memory transaction owned by a cache.
  bit           busy;
  bit           owner;
  bit           last;
  logic         e_we;
  logic [31:0]  e_addr;
  logic [127:0] e_wdata;
  bit           pend_i, pend_d, done_i, done_d;
  int           n_grant_i, n_grant_d;

  function automatic logic [127:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_reset();
    busy    = 0;
    owner   = PORT_I;
    last    = PORT_I;
    e_we    = 1'b0;
    e_addr  = '0;
    e_wdata = '0;
  endtask

  task automatic model_step();
    bit who;
    if (busy) begin
      if (m_ready) busy = 0;
    end else if (i_req || d_req) begin
      if (i_req && d_req) who = (last == PORT_I) ? PORT_D : PORT_I;
      else who = d_req ? PORT_D : PORT_I;
      busy  = 1;
      owner = who;
      last  = who;
      if (who == PORT_D) begin
        e_we = d_we; e_addr = d_addr; e_wdata = d_wdata;
        n_grant_d++;
      end else begin
        e_we = i_we; e_addr = i_addr; e_wdata = i_wdata;
        n_grant_i++;
      end
    end
  endtask

  task automatic drive_cache();
    if (done_i) pend_i = 0;
    if (done_d) pend_d = 0;
    if (!pend_i && ($urandom % 3 == 0)) begin
      pend_i  = 1;
      i_we    = $urandom % 2;
      i_addr  = $urandom & 32'hFFFF_FFF0;
      i_wdata = rnd_line();
    end else if (pend_i && ($urandom % 4 == 0)) begin
      i_addr  = $urandom & 32'hFFFF_FFF0;
      i_wdata = rnd_line();
      i_we    = $urandom % 2;
    end
    if (!pend_d && ($urandom % 2 == 0)) begin
      pend_d  = 1;
      d_we    = $urandom % 2;
      d_addr  = $urandom & 32'hFFFF_FFF0;
      d_wdata = rnd_line();
    end else if (pend_d && ($urandom % 4 == 0)) begin
      d_addr  = $urandom & 32'hFFFF_FFF0;
      d_wdata = rnd_line();
      d_we    = $urandom % 2;
    end
    i_req = pend_i;
    d_req = pend_d;
  endtask

  task automatic chk_regs();
    chk("m_req", m_req, busy);
    if (busy) begin
      chk("m_we", m_we, e_we);
      chk("m_addr", m_addr, e_addr);
      chk("m_wdata", m_wdata, e_wdata);
    end
  endtask

  initial begin
    rst = 1'b1;
    i_req = 0; i_we = 0; i_addr = '0; i_wdata = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    m_ready = 0; m_rdata = '0;
    pend_i = 0; pend_d = 0; done_i = 0; done_d = 0;
    n_grant_i = 0; n_grant_d = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_req", m_req, 1'b0);
    chk("rst_m_we", m_we, 1'b0);
    chk("rst_m_addr", m_addr, 32'h0);
    chk("rst_m_wdata", m_wdata, 128'h0);
    chk("rst_i_ready", i_ready, 1'b0);
    chk("rst_d_ready", d_ready, 1'b0);
    rst = 1'b0;

    // First contended request after reset must go to the dcache.
    i_req = 1; i_addr = 32'h0000_1230; i_we = 0;
    d_req = 1; d_addr = 32'h0000_0800; d_we = 1;
    d_wdata = rnd_line();
    pend_i = 1; pend_d = 1;

    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (cyc > 0) begin
        chk_regs();
        drive_cache();
      end
      m_ready = busy ? ($urandom % 3 == 0) : ($urandom % 8 == 0);
      m_rdata = rnd_line();
      #1;
      chk("i_ready", i_ready, busy && owner == PORT_I && m_ready);
      chk("d_ready", d_ready, busy && owner == PORT_D && m_ready);
      if (i_ready) chk("i_rdata", i_rdata, m_rdata);
      if (d_ready) chk("d_rdata", d_rdata, m_rdata);
      done_i = busy && owner == PORT_I && m_ready;
      done_d = busy && owner == PORT_D && m_ready;
      if (cyc % 250 == 137 && busy) begin
        rst = 1'b1;
        #1;
        chk("arst_m_req", m_req, 1'b0);
        chk("arst_i_ready", i_ready, 1'b0);
        chk("arst_d_ready", d_ready, 1'b0);
        model_reset();
        done_i = 0;
        done_d = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_ready = 0;
        chk("arst_hold_m_req", m_req, 1'b0);
        drive_cache();
        #1;
        model_step();
        @(posedge clk);
        #1;
        continue;
      end
      model_step();
      @(posedge clk);
      #1;
    end
    chk_regs();
    chk("grants_i_seen", n_grant_i > 20, 1'b1);
    chk("grants_d_seen", n_grant_d > 20, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
